// File: rtl/lfsr_prbs_engine_pkg.sv
// lfsr_prbs_engine_pkg: maximal-length default tap masks and parity helper
package lfsr_prbs_engine_pkg;
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0;
    endcase
  endfunction
  // 1 when the number of set bits is even
  function automatic logic even_parity(input logic [31:0] v);
    return ~^v;
  endfunction
endpackage

// File: rtl/lfsr_prbs_engine_if.sv
// lfsr_prbs_engine_if: control/seed inputs and PRBS status outputs
interface lfsr_prbs_engine_if #(parameter int WIDTH = 7);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH:0]   lfsr_out;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             seed_err;
  modport master (output en, load, seed, input lfsr_out, wrap, period, seed_err);
  modport slave  (input en, load, seed, output lfsr_out, wrap, period, seed_err);
endinterface

// File: rtl/lfsr_prbs_engine_step.sv
// lfsr_step: one Fibonacci LFSR shift with XOR feedback into bit 0
module lfsr_step #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'b1100000
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);
  assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
endmodule

// File: rtl/lfsr_prbs_engine.sv
// lfsr_prbs_engine: multi-step PRBS generator with period measurement
module lfsr_prbs_engine
  import lfsr_prbs_engine_pkg::*;
#(
  parameter int               WIDTH    = 7,
  parameter logic [WIDTH-1:0] TAPS     = 7'b1100000,
  parameter int               STEPS    = 1,
  parameter logic [WIDTH-1:0] SEED_RST = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic                clk,
  input logic                rst_n,
  lfsr_prbs_engine_if.slave  bus
);
  logic [WIDTH-1:0] state, ref_seed, cnt, period_q, load_val, cnt_inc;
  logic [WIDTH-1:0] chain [STEPS+1];
  logic             zero, hit, wrap_q, err_q;
  assign chain[0] = state;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (.cur(chain[i]), .nxt(chain[i+1]));
  end
  assign zero     = bus.seed == '0;
  assign load_val = zero ? SEED_RST : bus.seed;
  assign cnt_inc  = &cnt ? cnt : cnt + 1'b1;
  // only the end-of-cycle state is compared, so intermediate steps never wrap
  assign hit      = bus.en && !bus.load && chain[STEPS] == ref_seed;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEED_RST;
      ref_seed <= SEED_RST;
      cnt      <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= bus.load ? load_val : bus.en ? chain[STEPS] : state;
      wrap_q <= hit;
      err_q  <= bus.load && zero;
      if (bus.load) begin
        ref_seed <= load_val;
        cnt      <= '0;
      end else if (hit) begin
        period_q <= cnt_inc;
        cnt      <= '0;
      end else if (bus.en) begin
        cnt <= cnt_inc;
      end
    end
  end
  assign bus.lfsr_out = {even_parity(32'(state)), state};
  assign bus.wrap     = wrap_q;
  assign bus.period   = period_q;
  assign bus.seed_err = err_q;
endmodule

// File: tb/tb_lfsr_prbs_engine.sv
// tb_lfsr_prbs_engine: scoreboard bench comparing STEPS=1 and STEPS=2 builds to an orbit-index model
module tb_lfsr_prbs_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_prbs_engine_if #(.WIDTH(7)) b0 ();
  lfsr_prbs_engine_if #(.WIDTH(7)) b1 ();
  assign b1.en   = b0.en;
  assign b1.load = b0.load;
  assign b1.seed = b0.seed;

  lfsr_prbs_engine u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  lfsr_prbs_engine #(.STEPS(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct packed {
    logic [1:0][7:0] o;
    logic [1:0]      w;
    logic [1:0][6:0] p;
    logic [1:0]      e;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int tests = 0;
  int fails = 0;

  // Model: every nonzero state lies on the single 127-long orbit of 0x01,
  // so the LFSR is tracked as a position on that orbit.
  logic [6:0] orbit [127];
  int         idx   [128];
  int pos [2], rp [2], cnt [2], per [2];
  bit w [2], e [2];

  function automatic logic [6:0] step1(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit en, input bit ld, input logic [6:0] sd);
    exp_t x;
    int   s;
    @(negedge clk);
    rst_n   = r;
    b0.en   = en;
    b0.load = ld;
    b0.seed = sd;
    for (int d = 0; d < 2; d++) begin
      if (!r) begin
        pos[d] = 0; rp[d] = 0; cnt[d] = 0; per[d] = 0; w[d] = 0; e[d] = 0;
      end else if (ld) begin
        s      = (sd == 0) ? 1 : int'(sd);
        e[d]   = (sd == 0);
        w[d]   = 0;
        pos[d] = idx[s];
        rp[d]  = pos[d];
        cnt[d] = 0;
      end else begin
        e[d] = 0;
        w[d] = 0;
        if (en) begin
          pos[d] = (pos[d] + d + 1) % 127;
          w[d]   = (pos[d] == rp[d]);
          if (w[d]) begin
            per[d] = (cnt[d] + 1 > 127) ? 127 : cnt[d] + 1;
            cnt[d] = 0;
          end else begin
            cnt[d] = (cnt[d] == 127) ? 127 : cnt[d] + 1;
          end
        end
      end
      x.o[d] = {($countones(orbit[pos[d]]) % 2 == 0), orbit[pos[d]]};
      x.w[d] = w[d];
      x.p[d] = 7'(per[d]);
      x.e[d] = e[d];
    end
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("lfsr_out_s1", 32'(b0.lfsr_out), 32'(m.o[0]));
      chk("wrap_s1",     32'(b0.wrap),     32'(m.w[0]));
      chk("period_s1",   32'(b0.period),   32'(m.p[0]));
      chk("seed_err_s1", 32'(b0.seed_err), 32'(m.e[0]));
      chk("lfsr_out_s2", 32'(b1.lfsr_out), 32'(m.o[1]));
      chk("wrap_s2",     32'(b1.wrap),     32'(m.w[1]));
      chk("period_s2",   32'(b1.period),   32'(m.p[1]));
      chk("seed_err_s2", 32'(b1.seed_err), 32'(m.e[1]));
    end
  end

  initial begin
    logic [6:0] s;
    b0.en = 1'b0; b0.load = 1'b0; b0.seed = '0;
    s = 7'h01;
    for (int i = 0; i < 128; i++) idx[i] = 0;
    for (int i = 0; i < 127; i++) begin
      orbit[i] = s;
      idx[s]   = i;
      s        = step1(s);
    end
    repeat (2) cycle(0, 0, 0, 0);
    repeat (6) cycle(1, 1, 0, 0);
    cycle(0, 1, 1, 7'h33);
    repeat (127) cycle(1, 1, 0, 0);
    repeat (3) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 7'h00);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 7'h55);
    repeat (2) cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 7'($urandom_range(1, 127)));
    repeat (260) cycle(1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic ld;
      logic [6:0] sd;
      ld = ($urandom_range(0, 19) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, ld, sd);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries never checked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
